// File: rtl/mic_sample_sequencer.sv
// Pmod MIC3 conversion sequencer: drives chip-select and sclk at a fixed sample
// rate, shifts in each serial frame and keeps a windowed peak for the volume meter.
module mic_sample_sequencer #(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned SAMPLE_PERIOD = 5000,
  parameter int unsigned WINDOW        = 4000
) (
  input  logic        basys_clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        MISO,
  output logic        sclk,
  output logic        clk_samp,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic [11:0] peak_vol,
  output logic        peak_valid,
  output logic        busy
);

  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned HALF_W   = 5;
  localparam int unsigned SAMPLE_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HALF_W-1:0]   half_q, half_d;
  // Only the low 12 bits of the frame are kept; the 4 leading bits fall off the top.
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                sclk_q, sclk_d;
  logic                cs_q, cs_d;
  logic                busy_q, busy_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                sv_q, sv_d;
  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic                pv_q, pv_d;
  logic [SAMPLE_W-1:0] max_q, max_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic                div_last;
  logic [SAMPLE_W-1:0] larger;

  assign sclk         = sclk_q;
  assign clk_samp     = cs_q;
  assign sample       = sample_q;
  assign sample_valid = sv_q;
  assign peak_vol     = peak_q;
  assign peak_valid   = pv_q;
  assign busy         = busy_q;

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge basys_clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      half_q   <= '0;
      shift_q  <= '0;
      sclk_q   <= 1'b1;
      cs_q     <= 1'b1;
      busy_q   <= 1'b0;
      sample_q <= '0;
      sv_q     <= 1'b0;
      peak_q   <= '0;
      pv_q     <= 1'b0;
      max_q    <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      half_q   <= half_d;
      shift_q  <= shift_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      busy_q   <= busy_d;
      sample_q <= sample_d;
      sv_q     <= sv_d;
      peak_q   <= peak_d;
      pv_q     <= pv_d;
      max_q    <= max_d;
      win_q    <= win_d;
    end
  end

  // Next-state, pin timing, frame capture and windowed peak tracking.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    half_d   = half_q;
    shift_d  = shift_q;
    sclk_d   = 1'b1;
    cs_d     = 1'b1;
    busy_d   = 1'b0;
    sample_d = sample_q;
    sv_d     = 1'b0;
    peak_d   = peak_q;
    pv_d     = 1'b0;
    max_d    = max_q;
    win_d    = win_q;
    div_last = (div_q == DIV_W'(CLK_DIV - 1));
    larger   = (shift_q > max_q) ? shift_q : max_q;

    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(SAMPLE_PERIOD - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (!enable) begin
      // Abort or stay idle: pins return to their idle level, partial frame dropped.
      state_d = IDLE;
      div_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cnt_q == '0) begin
            state_d = SETUP;
            div_d   = '0;
            cs_d    = 1'b0;
            busy_d  = 1'b1;
          end
        end
        SETUP: begin
          cs_d   = 1'b0;
          busy_d = 1'b1;
          if (div_last) begin
            state_d = SHIFT;
            div_d   = '0;
            half_d  = '0;
            sclk_d  = 1'b0;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        SHIFT: begin
          cs_d   = 1'b0;
          busy_d = 1'b1;
          sclk_d = sclk_q;
          if (div_last) begin
            div_d = '0;
            if (half_q == HALF_W'(31)) begin
              state_d = HOLD;
              sclk_d  = 1'b1;
            end else begin
              half_d = half_q + HALF_W'(1);
              sclk_d = ~sclk_q;
              if (!sclk_q) begin
                shift_d = {shift_q[SAMPLE_W-2:0], MISO};
              end
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        HOLD: begin
          cs_d   = 1'b0;
          busy_d = 1'b1;
          if (div_last) begin
            state_d  = IDLE;
            div_d    = '0;
            cs_d     = 1'b1;
            busy_d   = 1'b0;
            sample_d = shift_q;
            sv_d     = 1'b1;
            if (win_q == WIN_W'(WINDOW - 1)) begin
              peak_d = larger;
              pv_d   = 1'b1;
              max_d  = '0;
              win_d  = '0;
            end else begin
              max_d = larger;
              win_d = win_q + WIN_W'(1);
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule
